ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Multi-cycle sequencer for ARMv4 LDM/STM (block data transfer). It walks a 16-bit register list, reading the register bank and issuing memory stores for STM, or accepting memory load data and writing it into the register bank for LDM. It optionally writes the updated base back to the base register. It sits between the execute stage and the register bank/data-memory ports, owning those ports while `busy` is high.

## Interface
- `REG_ADDR_W`, 4: register-bank address width (16 registers).
- `DATA_W`, 32: data and address width.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: launch request; sampled only in IDLE.
- `reglist` in 16: bit i set means transfer register ri.
- `base` in DATA_W: base address value (Rn contents).
- `base_reg` in REG_ADDR_W: Rn index, used for writeback.
- `load` in 1: 1 for LDM, 0 for STM.
- `pre` in 1: P bit; 1 means pre-index.
- `up` in 1: U bit; 1 means increment.
- `writeback` in 1: W bit.
- `busy` out 1: high from SETUP through DONE.
- `done` out 1: one-cycle pulse in DONE.
- `rf_raddr` out REG_ADDR_W: register-bank read address.
- `rf_rdata` in DATA_W: combinational read data for `rf_raddr`.
- `rf_waddr` out REG_ADDR_W, `rf_wdata` out DATA_W, `rf_we` out 1: register-bank write port.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out DATA_W, `mem_wdata` out DATA_W: memory request.
- `mem_ack` in 1: request accepted or completed; may be high in the same cycle as `mem_req`.
- `mem_rdata` in DATA_W: load data, valid when `mem_ack` is high.

## Operation
- **States:** IDLE, SETUP, XFER, LWR, WBACK, DONE.
- **IDLE → SETUP** when `start` is high. Capture `reglist`, `base`, `base_reg`, `load`, `pre`, `up`, `writeback`. Input changes after capture are ignored.
- **SETUP:**
  - n = popcount(reglist).
  - Start address: IA = base; IB = base+4; DA = base−4n+4; DB = base−4n.
  - New base = up ? base+4n : base−4n, modulo 2^32.
  - Registers always transfer in ascending index order to ascending addresses.
  - If n = 0, go to DONE with no transfers and no writeback. Otherwise go to XFER.
- **XFER:**
  - Outputs: `mem_req` = 1, `mem_we` = !load, `mem_addr` = current address with bits [1:0] forced to 0.
  - `rf_raddr` = current register; for STM, `mem_wdata` = `rf_rdata`.
  - All request outputs are held stable until `mem_ack` is high at a rising edge.
  - On ack: address += 4. For LDM, register `mem_rdata` and go to LWR. For STM, advance to the next set bit; after the last bit go to WBACK if writeback, else DONE.
- **LWR:** `rf_we` = 1, `rf_waddr` = current register, `rf_wdata` = captured load data. Then advance as in STM.
- **WBACK:** `rf_we` = 1, `rf_waddr` = base_reg, `rf_wdata` = new base. Then go to DONE.
  - LDM with base_reg in reglist: WBACK is skipped; the loaded value wins.
  - STM with base_reg in reglist: the stored value is the original base, because writeback happens last.
- **DONE:** `done` = 1, then IDLE.
- r15 in the list is an ordinary register write; PC redirection is the consumer's job.

## Timing
- **Reset values:** every output is 0, state is IDLE, captured registers are cleared.
- **Reset mid-operation:** returns to IDLE immediately. No further requests or writes are issued; already-completed transfers stand.
- **Latency** from the `start` edge to `done`, with zero-wait ack:
  - STM: 1 + n + w + 1 cycles.
  - LDM: 1 + 2n + w + 1 cycles.
  - w = 1 when WBACK executes, else 0.
- Each ack wait cycle adds one cycle.
- `start` is ignored while `busy` is high. `start` held high in DONE relaunches on the first IDLE cycle.
- `rf_we` and `mem_req` are never high in the same cycle.

## Structure
- **Shared package `armv4_pkg`:**
  - `seq_state_t` enum holding the six states.
  - `WORD_BYTES` = 4.
  - `NUM_REGS` = 16.
- **Sub-module `reglist_priority_enc`:** combinational.
  - Input: 16-bit mask.
  - Outputs: lowest set index (4-bit), `any` flag, popcount (5-bit).
  - Used in SETUP for n, and per step with cleared bits to find the next register.

## Test plan
- **STMIA, zero-wait ack.** reglist=0x0006, base=0x100, W=1, base_reg=0, r1=0xAA, r2=0xBB. Required:
  - store 0xAA to 0x100, then 0xBB to 0x104;
  - r0 ← 0x108;
  - `done` 5 cycles after `start`.
- **LDMDB with ack stalls.** reglist=0x8010, base=0x200, ack delayed 2 cycles per request. Required:
  - loads from 0x1F8→r4 and 0x1FC→r15;
  - requests held stable during stalls;
  - no writeback with W=0.
- **LDMIB, base in list.** base_reg=3, reglist=0x0008, W=1. Required: r3 gets the loaded word from base+4; no WBACK cycle.
- **Empty list.** reglist=0. Required: `done` 2 cycles after `start`; `mem_req` and `rf_we` never assert.
- **Reset mid-transfer.** Assert `reset` during the 2nd XFER of a 4-register STM. Required: all outputs 0 immediately; no 3rd store; a new `start` after release runs normally.
- **STMDA with wrap-around.** base=0x4, reglist=0x0003, W=1. Required:
  - addresses 0x0 and 0x4;
  - writeback 0xFFFFFFFC (hmm: base−8 = −4 → 0xFFFFFFFC).

Source files
------------

// File: rtl/armv4_pkg.sv
// rtl/armv4_pkg.sv - shared types and constants for the LDM/STM sequencer
package armv4_pkg;

  localparam int WORD_BYTES = 4;
  localparam int NUM_REGS   = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    LWR,
    WBACK,
    DONE
  } seq_state_t;

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// rtl/ldm_stm_sequencer_if.sv - command, register-bank and data-memory bus of the sequencer
interface ldm_stm_sequencer_if #(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32
);
  import armv4_pkg::*;

  logic                  start;
  logic [NUM_REGS-1:0]   reglist;
  logic [DATA_W-1:0]     base;
  logic [REG_ADDR_W-1:0] base_reg;
  logic                  load;
  logic                  pre;
  logic                  up;
  logic                  writeback;
  logic                  busy;
  logic                  done;

  logic [REG_ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0]     rf_rdata;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  rf_we;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  start, reglist, base, base_reg, load, pre, up, writeback,
    output busy, done,
    output rf_raddr, input rf_rdata, output rf_waddr, rf_wdata, rf_we,
    output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata
  );

  modport slave (
    output start, reglist, base, base_reg, load, pre, up, writeback,
    input  busy, done,
    input  rf_raddr, output rf_rdata, input rf_waddr, rf_wdata, rf_we,
    input  mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata
  );

endinterface

// File: rtl/reglist_priority_enc.sv
// rtl/reglist_priority_enc.sv - lowest-set-bit index, any flag and popcount of a register list
module reglist_priority_enc
  import armv4_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  output logic [3:0]          idx,
  output logic                any,
  output logic [4:0]          count
);

  always_comb begin
    idx   = '0;
    count = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      count = count + 5'(mask[i]);
    end
    any = |mask;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - ARMv4 LDM/STM block transfer sequencer
module ldm_stm_sequencer
  import armv4_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  ldm_stm_sequencer_if.master  bus
);

  seq_state_t            state, state_nx;
  logic [NUM_REGS-1:0]   mask_q;
  logic [DATA_W-1:0]     base_q, addr_q, new_base_q, ldata_q;
  logic [REG_ADDR_W-1:0] base_reg_q, cur_q;
  logic                  load_q, pre_q, up_q, wb_q;

  logic [3:0]            enc_idx;
  logic                  enc_any;
  logic [4:0]            enc_cnt;
  logic [NUM_REGS-1:0]   idx_bit;
  logic [DATA_W-1:0]     span, start_addr;
  seq_state_t            after_reg;

  // mask_q holds only the registers not yet started, so the encoder gives n in SETUP
  // and the next register afterwards
  reglist_priority_enc u_enc (
    .mask  (mask_q),
    .idx   (enc_idx),
    .any   (enc_any),
    .count (enc_cnt)
  );

  assign idx_bit   = NUM_REGS'(1) << enc_idx;
  assign span      = DATA_W'({enc_cnt, 2'b00});
  assign after_reg = enc_any ? XFER : (wb_q ? WBACK : DONE);

  always_comb begin
    unique case ({pre_q, up_q})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + DATA_W'(WORD_BYTES);
      2'b00:   start_addr = base_q - span + DATA_W'(WORD_BYTES);
      default: start_addr = base_q - span;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.rf_raddr  = '0;
    bus.rf_waddr  = '0;
    bus.rf_wdata  = '0;
    bus.rf_we     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE:  if (bus.start) state_nx = SETUP;
      SETUP: state_nx = enc_any ? XFER : DONE;
      XFER: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = !load_q;
        bus.mem_addr = {addr_q[DATA_W-1:2], 2'b00};
        bus.rf_raddr = cur_q;
        if (!load_q) bus.mem_wdata = bus.rf_rdata;
        if (bus.mem_ack) state_nx = load_q ? LWR : after_reg;
      end
      LWR: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = cur_q;
        bus.rf_wdata = ldata_q;
        state_nx     = after_reg;
      end
      WBACK: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = base_reg_q;
        bus.rf_wdata = new_base_q;
        state_nx     = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      new_base_q <= '0;
      ldata_q    <= '0;
      base_reg_q <= '0;
      cur_q      <= '0;
      load_q     <= 1'b0;
      pre_q      <= 1'b0;
      up_q       <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mask_q     <= bus.reglist;
          base_q     <= bus.base;
          base_reg_q <= bus.base_reg;
          load_q     <= bus.load;
          pre_q      <= bus.pre;
          up_q       <= bus.up;
          wb_q       <= bus.writeback;
        end
        SETUP: begin
          addr_q     <= start_addr;
          new_base_q <= up_q ? base_q + span : base_q - span;
          // a loaded base register must keep the loaded value
          wb_q       <= wb_q && !(load_q && mask_q[base_reg_q]);
          if (enc_any) begin
            cur_q  <= REG_ADDR_W'(enc_idx);
            mask_q <= mask_q & ~idx_bit;
          end
        end
        XFER: if (bus.mem_ack) begin
          addr_q <= addr_q + DATA_W'(WORD_BYTES);
          if (load_q) begin
            ldata_q <= bus.mem_rdata;
          end else if (enc_any) begin
            cur_q  <= REG_ADDR_W'(enc_idx);
            mask_q <= mask_q & ~idx_bit;
          end
        end
        LWR: if (enc_any) begin
          cur_q  <= REG_ADDR_W'(enc_idx);
          mask_q <= mask_q & ~idx_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - scoreboard bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_delay = 0;
  int   wait_cnt;
  logic [31:0] regs     [16];
  logic [31:0] init_val [16];
  logic        init_go = 1'b0;
  ev_t         exp_q [$];
  logic        prev_stall = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;

  ldm_stm_sequencer_if #(.REG_ADDR_W(4), .DATA_W(32)) bus ();

  ldm_stm_sequencer #(.REG_ADDR_W(4), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hD000_0000 | a;
  endfunction

  assign bus.rf_rdata  = regs[bus.rf_raddr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
  assign bus.mem_rdata = (bus.mem_req && !bus.mem_we) ? mem_word(bus.mem_addr) : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
    else if (init_go) regs <= init_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.is_mem = 1'b1; e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_rf(input int idx, input logic [31:0] data);
    ev_t e;
    e.is_mem = 1'b0; e.we = 1'b1; e.addr = 32'(idx); e.data = data;
    exp_q.push_back(e);
  endtask

  // scoreboard and protocol monitor
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.busy) check("req_we_exclusive", 32'(bus.mem_req & bus.rf_we), 32'h0);
      if (prev_stall) begin
        check("stall_req",   32'(bus.mem_req), 32'h1);
        check("stall_we",    32'(bus.mem_we), 32'(prev_we));
        check("stall_addr",  bus.mem_addr, prev_addr);
        check("stall_wdata", bus.mem_wdata, prev_wdata);
      end
      if (bus.mem_req && bus.mem_ack) begin
        check("mem_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mem_kind",  32'h1, 32'(e.is_mem));
          check("mem_we",    32'(bus.mem_we), 32'(e.we));
          check("mem_addr",  bus.mem_addr, e.addr);
          check("mem_wdata", bus.mem_wdata, e.data);
        end
      end
      if (bus.rf_we) begin
        check("rf_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rf_kind",  32'h0, 32'(e.is_mem));
          check("rf_waddr", 32'(bus.rf_waddr), e.addr);
          check("rf_wdata", bus.rf_wdata, e.data);
        end
      end
      prev_stall = bus.mem_req && !bus.mem_ack;
      prev_we    = bus.mem_we;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end
  end

  task automatic default_vals();
    for (int i = 0; i < 16; i++) init_val[i] = 32'h5A00_0000 | 32'(i);
  endtask

  task automatic commit_regs();
    init_go = 1'b1;
    @(posedge clk); #1;
    init_go = 1'b0;
  endtask

  task automatic drive_cmd(input logic [15:0] rl, input logic [31:0] b, input logic [3:0] br,
                           input logic ld, input logic p, input logic u, input logic w);
    @(negedge clk);
    bus.start = 1'b1; bus.reglist = rl; bus.base = b; bus.base_reg = br;
    bus.load = ld; bus.pre = p; bus.up = u; bus.writeback = w;
    @(posedge clk); #1;
    // scramble the command after capture; the sequencer must ignore it
    bus.start = 1'b0; bus.reglist = 16'($urandom); bus.base = $urandom;
    bus.base_reg = 4'($urandom); bus.load = ~ld; bus.pre = ~p; bus.up = ~u; bus.writeback = ~w;
  endtask

  task automatic run_op(input string tag, input logic [15:0] rl, input logic [31:0] b,
                        input logic [3:0] br, input logic ld, input logic p, input logic u,
                        input logic w, input int exp_lat);
    int cyc;
    drive_cmd(rl, b, br, ld, p, u, w);
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 32'(bus.busy), 32'h0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.reglist = '0; bus.base = '0; bus.base_reg = '0;
    bus.load = 1'b0; bus.pre = 1'b0; bus.up = 1'b0; bus.writeback = 1'b0;
    default_vals();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {27'h0, bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.rf_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_rf_wdata", bus.rf_wdata, 32'h0);
    reset = 1'b0;
    commit_regs();

    // STMIA r1,r2 with writeback to r0
    default_vals(); init_val[1] = 32'hAA; init_val[2] = 32'hBB; commit_regs();
    push_mem(1'b1, 32'h100, 32'hAA);
    push_mem(1'b1, 32'h104, 32'hBB);
    push_rf(0, 32'h108);
    run_op("stmia", 16'h0006, 32'h100, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5);

    // LDMDB r4,r15 with two-cycle ack stalls, no writeback
    ack_delay = 2;
    push_mem(1'b0, 32'h1F8, 32'h0); push_rf(4,  mem_word(32'h1F8));
    push_mem(1'b0, 32'h1FC, 32'h0); push_rf(15, mem_word(32'h1FC));
    run_op("ldmdb", 16'h8010, 32'h200, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 10);
    ack_delay = 0;

    // LDMIB with base register in the list: loaded value wins, no WBACK
    push_mem(1'b0, 32'h304, 32'h0); push_rf(3, mem_word(32'h304));
    run_op("ldmib_base", 16'h0008, 32'h300, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4);

    // empty list
    run_op("empty", 16'h0000, 32'h700, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2);

    // reset during the second store of a four-register STMIA
    default_vals(); commit_regs();
    push_mem(1'b1, 32'h400, 32'h5A00_0004);
    drive_cmd(16'h00F0, 32'h400, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_in_xfer", 32'(bus.mem_req), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_ctrl", {27'h0, bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.rf_we}, 32'h0);
    check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    check("mid_rst_mem_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_queue", 32'(exp_q.size()), 32'h0);
    push_mem(1'b1, 32'h500, 32'h5A00_0000);
    push_mem(1'b1, 32'h504, 32'h5A00_0001);
    push_rf(5, 32'h508);
    run_op("after_reset", 16'h0003, 32'h500, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5);

    // STMDA with address wrap-around on writeback
    default_vals(); commit_regs();
    push_mem(1'b1, 32'h0, 32'h5A00_0000);
    push_mem(1'b1, 32'h4, 32'h5A00_0001);
    push_rf(2, 32'hFFFF_FFFC);
    run_op("stmda_wrap", 16'h0003, 32'h4, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5);

    // STMIB with base in list and one-cycle stalls: original r3 is stored
    ack_delay = 1;
    push_mem(1'b1, 32'h804, 32'h5A00_0000);
    push_mem(1'b1, 32'h808, 32'h5A00_0003);
    push_rf(3, 32'h808);
    run_op("stmib_base", 16'h0009, 32'h800, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 7);
    ack_delay = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
